// File: rtl/stage_buffer_pkg.sv
// stage_buffer_pkg: default widths, NOP control value and payload bundle shared by the stage buffer
package stage_buffer_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int BYTE_W_DEF = 8;
    localparam int FWD_W_DEF  = 4;
    localparam int CTRL_W_DEF = 4;

    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

    typedef struct packed {
        logic [WORD_W_DEF-1:0] word;
        logic [BYTE_W_DEF-1:0] byte_f;
        logic [FWD_W_DEF-1:0]  fwd;
        logic [CTRL_W_DEF-1:0] ctrl;
    } payload_t;

endpackage

// File: rtl/stage_buffer_entry.sv
// stage_buffer_entry: one payload register with load enable, valid flag and synchronous clear
module stage_buffer_entry #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic         full_d,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         full
);

    // reset wipes payload and flag; clear empties the entry but keeps its payload visible
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '0;
            full <= 1'b0;
        end else begin
            if (ld)
                q <= d;
            full <= clr ? 1'b0 : full_d;
        end
    end

endmodule

// File: rtl/stage_buffer.sv
// stage_buffer: two-entry skid buffer with registered in_ready, flush and occupancy count
module stage_buffer
    import stage_buffer_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int FWD_W  = FWD_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              C,
    input  logic              R,
    input  logic [WORD_W-1:0] IW,
    input  logic [BYTE_W-1:0] IB,
    input  logic [FWD_W-1:0]  IF,
    input  logic [CTRL_W-1:0] IC,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [WORD_W-1:0] OW,
    output logic [BYTE_W-1:0] OB,
    output logic [FWD_W-1:0]  OF,
    output logic [CTRL_W-1:0] OC,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        level
);

    localparam int PW = WORD_W + BYTE_W + FWD_W + CTRL_W;

    logic [PW-1:0] in_p, m_d, m_q, s_q;
    logic          m_full, s_full, m_full_d, s_full_d, m_ld, s_ld, acc, xfer, rdy;

    assign in_p = {IW, IB, IF, IC};

    // steering: skid refills main on drain, otherwise input goes to main when it frees up, else to skid
    always_comb begin
        acc      = in_valid & rdy;
        xfer     = m_full & out_ready;
        m_ld     = ~flush & ((xfer & s_full) | (acc & (xfer | ~m_full)));
        m_d      = s_full ? s_q : in_p;
        s_ld     = ~flush & acc & m_full & ~xfer;
        m_full_d = m_full ? (~xfer | s_full | acc) : acc;
        s_full_d = s_full ? ~xfer : s_ld;
    end

    stage_buffer_entry #(.W(PW)) u_main (
        .clk    (C),
        .rst_n  (R),
        .clr    (flush),
        .ld     (m_ld),
        .full_d (m_full_d),
        .d      (m_d),
        .q      (m_q),
        .full   (m_full)
    );

    stage_buffer_entry #(.W(PW)) u_skid (
        .clk    (C),
        .rst_n  (R),
        .clr    (flush),
        .ld     (s_ld),
        .full_d (s_full_d),
        .d      (in_p),
        .q      (s_q),
        .full   (s_full)
    );

    // in_ready is registered from the next skid state so out_ready never reaches it combinationally
    always_ff @(posedge C) begin
        if (!R)
            rdy <= 1'b0;
        else
            rdy <= flush | ~s_full_d;
    end

    assign in_ready     = rdy;
    assign out_valid    = m_full;
    assign {OW, OB, OF} = m_q[PW-1:CTRL_W];
    assign OC           = m_full ? m_q[CTRL_W-1:0] : CTRL_W'(CTRL_NOP);
    assign level        = {1'b0, m_full} + {1'b0, s_full};

endmodule

// File: tb/tb_stage_buffer.sv
// tb_stage_buffer: directed and randomized checks of stage_buffer against a queue-based model
module tb_stage_buffer;
    import stage_buffer_pkg::*;

    logic        C = 1'b0, R = 1'b0;
    logic [15:0] IW = '0;
    logic [7:0]  IB = '0;
    logic [3:0]  IF = '0, IC = '0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [15:0] OW;
    logic [7:0]  OB;
    logic [3:0]  OF, OC;
    logic [1:0]  level;

    logic [31:0] w_iw = '0;
    logic [5:0]  w_ic = '0;
    logic        w_in_valid = 1'b0;
    logic        w_in_ready, w_out_valid;
    logic [31:0] w_ow;
    logic [7:0]  w_ob;
    logic [3:0]  w_of;
    logic [5:0]  w_oc;
    logic [1:0]  w_level;

    int checks = 0, errors = 0;

    payload_t q[$];
    payload_t last = '0;
    bit       rdy = 1'b0;

    always #5 C = ~C;

    stage_buffer dut (
        .C(C), .R(R), .IW(IW), .IB(IB), .IF(IF), .IC(IC),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .OW(OW), .OB(OB), .OF(OF), .OC(OC),
        .out_valid(out_valid), .out_ready(out_ready), .level(level)
    );

    stage_buffer #(.WORD_W(32), .CTRL_W(6)) dut_w (
        .C(C), .R(R), .IW(w_iw), .IB(8'h5A), .IF(4'h3), .IC(w_ic),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .flush(1'b0),
        .OW(w_ow), .OB(w_ob), .OF(w_of), .OC(w_oc),
        .out_valid(w_out_valid), .out_ready(1'b1), .level(w_level)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [15:0] w, input logic [7:0] b,
                         input logic [3:0] f, input logic [3:0] c, input bit ordy, input bit fl);
        in_valid = v; IW = w; IB = b; IF = f; IC = c; out_ready = ordy; flush = fl;
    endtask

    task automatic tick();
        payload_t p;
        bit pop, push;
        @(posedge C);
        p = '{word: IW, byte_f: IB, fwd: IF, ctrl: IC};
        if (!R) begin
            q.delete(); rdy = 1'b0; last = '0;
        end else if (flush) begin
            q.delete(); rdy = 1'b1;
        end else begin
            pop  = q.size() > 0 && out_ready;
            push = in_valid && rdy;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(p);
            rdy = q.size() < 2;
        end
        if (q.size() > 0) last = q[0];
        @(negedge C);
        check("in_ready", in_ready, rdy);
        check("out_valid", out_valid, q.size() > 0);
        check("level", level, q.size());
        check("OW", OW, last.word);
        check("OB", OB, last.byte_f);
        check("OF", OF, last.fwd);
        check("OC", OC, q.size() > 0 ? last.ctrl : 4'h0);
    endtask

    initial begin
        @(negedge C);
        R = 1'b0;
        drive(1, 16'h1111, 8'h11, 4'h1, 4'h1, 1, 0);
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_OC", OC, 0);
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 0);
        R = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        check("post_rst_in_ready", in_ready, 1);

        drive(1, 16'hA237, 8'hF0, 4'hF, 4'h1, 1, 0);
        tick();
        check("pt_OW", OW, 16'hA237);
        check("pt_OB", OB, 8'hF0);
        check("pt_OF", OF, 4'hF);
        check("pt_OC", OC, 4'h1);
        check("pt_out_valid", out_valid, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        check("pt_drain_valid", out_valid, 0);
        check("pt_drain_OC", OC, 0);

        drive(1, 16'h0001, 8'h01, 4'h1, 4'h2, 0, 0);
        tick();
        drive(1, 16'h0002, 8'h02, 4'h2, 4'h3, 0, 0);
        tick();
        check("bp_level", level, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_OW_first", OW, 16'h0001);
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        check("bp_OW_second", OW, 16'h0002);
        check("bp_in_ready_back", in_ready, 1);
        tick();
        check("bp_empty", out_valid, 0);

        for (int n = 0; n < 8; n++) begin
            drive(1, 16'h8400 + 16'(n), 8'(n), 4'(n), 4'h4, 1, 0);
            tick();
            check("st_OW", OW, 16'h8400 + 16'(n));
            check("st_level", level, 1);
            check("st_in_ready", in_ready, 1);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();

        drive(1, 16'h0A0A, 8'h0A, 4'hA, 4'h5, 0, 0);
        tick();
        drive(1, 16'h0B0B, 8'h0B, 4'hB, 4'h6, 0, 0);
        tick();
        check("fl_level_before", level, 2);
        drive(1, 16'hDEAD, 8'hDE, 4'hD, 4'h7, 0, 1);
        tick();
        check("fl_level", level, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_OC", OC, 0);
        check("fl_in_ready", in_ready, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fl_no_dead", OW == 16'hDEAD, 0);
        end

        w_in_valid = 1'b1; w_iw = 32'hCAFE_0123; w_ic = 6'h21;
        tick();
        check("w_OW", w_ow, 32'hCAFE_0123);
        check("w_OC", w_oc, 6'h21);
        check("w_out_valid", w_out_valid, 1);
        w_in_valid = 1'b0;
        tick();
        check("w_drain_valid", w_out_valid, 0);
        check("w_drain_OC", w_oc, 0);

        for (int i = 0; i < 400; i++) begin
            R = $urandom_range(0, 49) != 0;
            drive($urandom_range(0, 2) != 0, 16'($urandom), 8'($urandom), 4'($urandom),
                  4'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_buffer.md
STAGE_BUFFER -- requirements
Module: stage_buffer

Interface
REQ-001 Parameter WORD_W, default 16: width of the word payload field.
REQ-002 Parameter BYTE_W, default 8: width of the byte payload field.
REQ-003 Parameter FWD_W, default 4: width of the forwarding-tag field.
REQ-004 Parameter CTRL_W, default 4: width of the control field; the all-zero control value is the NOP (bubble).
REQ-005 C  input  1: clock; all state SHALL change on its rising edge only.
REQ-006 R  input  1: reset; synchronous and active-low.
REQ-007 IW / IB / IF / IC  input  WORD_W / BYTE_W / FWD_W / CTRL_W: upstream payload fields.
REQ-008 in_valid  input  1: upstream payload is valid this cycle.
REQ-009 in_ready  output  1: the block accepts the payload this cycle.
REQ-010 flush  input  1: discard all held entries.
REQ-011 OW / OB / OF / OC  output  WORD_W / BYTE_W / FWD_W / CTRL_W: downstream payload fields.
REQ-012 out_valid  output  1: output payload is valid.
REQ-013 out_ready  input  1: downstream consumes the payload this cycle.
REQ-014 level  output  2: number of occupied entries (0..2).

Function
REQ-015 The block SHALL be a two-entry skid buffer consisting of a main (output) entry and a skid entry, with no combinational path from out_ready to in_ready.
REQ-016 in_ready SHALL be registered and equal to NOT (skid entry full).
REQ-017 Accept occurs when in_valid=1 and in_ready=1; transfer-out occurs when out_valid=1 and out_ready=1.
REQ-018 out_valid SHALL equal main-full; OW/OB/OF SHALL present the main entry.
REQ-019 OC SHALL be the main entry's control field when out_valid=1, and all-zero otherwise.
REQ-020 Latency: a payload accepted into an empty block SHALL appear on the outputs with out_valid=1 exactly one cycle later.
REQ-021 Transfer-out with skid full: skid moves to main and skid becomes empty; a concurrent accept is impossible because in_ready=0.
REQ-022 Transfer-out with skid empty and an accept: input loads main, which stays full.
REQ-023 Transfer-out with skid empty and no accept: main becomes empty.
REQ-024 No transfer-out, main full, and an accept: input loads skid.
REQ-025 Main empty and an accept: input loads main.
REQ-026 Entries SHALL be delivered strictly in acceptance order; no payload may be dropped or duplicated except by flush.
REQ-027 flush=1 SHALL empty both entries at the next edge; an accept in the same cycle is discarded, and flush has priority over all other events.
REQ-028 After a flush, in_ready=1 and out_valid=0; data fields hold their last values while OC reads zero.
REQ-029 level SHALL equal main-full + skid-full, updated on the same edge as the entries.
REQ-030 A transfer-out and an accept in the same cycle at level 1 SHALL leave level at 1.

Reset
REQ-031 When R=0 at a rising edge of C, both entries SHALL become empty and all payload registers SHALL clear to zero.
REQ-032 During reset, in_ready=0, out_valid=0, OW/OB/OF/OC=0, and level=0.
REQ-033 in_ready SHALL be 1 in the first cycle after R returns to 1.
REQ-034 Reset SHALL take priority over flush and all traffic; reset applied mid-operation discards held entries.

Structure
REQ-035 The shared package SHALL hold the default width constants, the NOP control constant (all-zero), and a payload bundle type {word, byte, fwd, ctrl}.
REQ-036 Each entry SHALL be an instance of one sub-module, stage_buffer_entry: a payload register with load enable, valid flag, and synchronous clear.
REQ-037 The top level SHALL contain only the steering and control logic, within 120-400 lines of RTL in total.

Verification
REQ-038 Reset scenario: R=0 for 2 cycles, then R=1 → out_valid=0, OC=4'h0, and level=0 during reset; in_ready=1 in the first cycle after.
REQ-039 Pass-through scenario: out_ready=1; send IW=16'hA237, IB=8'hF0, IF=4'hF, IC=4'h1 for one cycle → next cycle OW=A237, OB=F0, OF=F, OC=1, out_valid=1; one cycle later out_valid=0 and OC=0.
REQ-040 Back-pressure scenario: out_ready=0; send IW=16'h0001, then 16'h0002 → level=2 and in_ready=0; raise out_ready → OW=0001 then 0002 on consecutive cycles, and in_ready=1 one cycle after the first transfer-out.
REQ-041 Streaming scenario: out_ready=1 and in_valid=1 for 8 cycles with IW=16'h8400+n → OW=8400..8407 in order, level constant at 1, in_ready never 0.
REQ-042 Flush scenario: level=2, then assert flush with in_valid=1 and IW=16'hDEAD → next cycle level=0, out_valid=0, OC=0, and 16'hDEAD never appears on OW.
REQ-043 Parametrisation scenario: WORD_W=32, CTRL_W=6; repeat the pass-through scenario with IW=32'hCAFE_0123 → identical timing, full-width data reproduced on OW.
